// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the shift-and-add multiply sequencer:
// ALU control codes, FSM state encoding and the N/Z flag helper.
package alu_mul_seq_pkg;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   function automatic logic [1:0] nz_flags(input logic [31:0] value);
      return {value[31], (value == '0)};
   endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// MUL / MLA sequencer: borrows the shared 32-bit ALU through req/gnt and
// accumulates the low 32 bits of A*B (+C) one multiplier bit per granted cycle.
module alu_mul_seq
   import alu_mul_seq_pkg::*;
#(
   parameter bit EARLY_TERM = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        op_mla,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [1:0]  flags_nz,
   output logic        alu_req,
   input  logic        alu_gnt,
   output logic [1:0]  alu_control,
   output logic [31:0] alu_srca,
   output logic [31:0] alu_srcb,
   input  logic [31:0] alu_result
);

   state_t      state;
   state_t      state_next;
   logic [31:0] acc;
   logic [31:0] mcand;
   logic [31:0] mplier;
   logic [4:0]  count;
   logic [31:0] acc_step;
   logic        iter_last;
   logic        start_zero;

   always_comb begin
      acc_step   = mplier[0] ? alu_result : acc;
      iter_last  = (EARLY_TERM && (mplier[31:1] == '0)) || (count == 5'd31);
      start_zero = EARLY_TERM && (b == '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = start_zero ? DONE : RUN;
         RUN:     if (alu_gnt && iter_last) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state != IDLE);
      done        = (state == DONE);
      alu_req     = (state == RUN);
      alu_control = ALU_ADD;
      alu_srca    = (state == RUN) ? acc   : '0;
      alu_srcb    = (state == RUN) ? mcand : '0;
   end

   // result/flags load on the same edge that enters DONE, so they are valid with done
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         count    <= '0;
         result   <= '0;
         flags_nz <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= a;
                  mplier <= b;
                  acc    <= op_mla ? c : '0;
                  count  <= '0;
                  if (start_zero) begin
                     result   <= op_mla ? c : '0;
                     flags_nz <= nz_flags(op_mla ? c : '0);
                  end
               end
            end
            RUN: begin
               if (alu_gnt) begin
                  acc    <= acc_step;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  count  <= count + 5'd1;
                  if (iter_last) begin
                     result   <= acc_step;
                     flags_nz <= nz_flags(acc_step);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle multiply / multiply-accumulate sequencer that borrows the shared 32-bit ALU (2-bit control: add/sub/and/or) to compute MUL and MLA results with shift-and-add.
- Sits beside the decode/control logic.
- Requests ALU ownership through a req/gnt pair while active.
- Hands back the low 32 bits of the product and N/Z flags with a one-cycle done pulse.

## Interface
Parameters:
- EARLY_TERM, 1, 1: stop when the remaining multiplier bits are zero; 0: always run 32 iterations.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only in IDLE.
- op_mla  in  1  0 = MUL (A*B), 1 = MLA (A*B + C).
- a  in  32  multiplicand.
- b  in  32  multiplier.
- c  in  32  addend; ignored when op_mla = 0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; result is valid.
- result  out  32  low 32 bits of the product (plus C); held until the next accepted start.
- flags_nz  out  2  {N, Z} of result; held with result.
- alu_req  out  1  requests the shared ALU; high in RUN.
- alu_gnt  in  1  ALU granted this cycle.
- alu_control  out  2  driven to add (00) in RUN, otherwise 00.
- alu_srca  out  32  accumulator in RUN, otherwise 0.
- alu_srcb  out  32  shifted multiplicand in RUN, otherwise 0.
- alu_result  in  32  shared ALU result. alu_flags are not consumed.

## Operation
- States:
  - IDLE: wait for start.
  - RUN: iterate shift-and-add.
  - DONE: pulse done for one cycle.
- Reset: state = IDLE. busy, done, alu_req, result, flags_nz, the internal accumulator, mcand, mplier and count are all 0.
- IDLE, start = 1: capture mcand = a, mplier = b, acc = op_mla ? c : 0, count = 0.
  - Next state is DONE if b == 0 and EARLY_TERM = 1; otherwise RUN.
- RUN, alu_gnt = 0: hold all state; ALU outputs stay driven.
- RUN, alu_gnt = 1 (one iteration):
  - if mplier[0], acc <= alu_result (= acc + mcand).
  - mcand <<= 1 (logical); mplier >>= 1 (logical); count += 1.
  - Go to DONE if (EARLY_TERM and (mplier >> 1) == 0) or count == 31. Otherwise stay in RUN.
- DONE: done = 1 for exactly one cycle, then return to IDLE.
  - On entry to DONE, result and flags_nz register acc: N = acc[31], Z = (acc == 0).
- Arithmetic: all addition is modulo 2^32. Signed and unsigned low-32 products are identical, so there is no sign handling.
- start while busy is ignored (not queued). start in the DONE cycle is also ignored.
- Inputs a, b, c and op_mla are don't-care after the capture edge.

## Timing
- Latency from the start-sampling edge to the done-high cycle, with alu_gnt held high:
  - b == 0 and EARLY_TERM = 1: 1 cycle.
  - Otherwise, EARLY_TERM = 1: msb(b) + 2 cycles.
  - Otherwise, EARLY_TERM = 0: 33 cycles.
- Each low-gnt cycle in RUN adds exactly 1 cycle of latency.
- Minimum start-to-start spacing: latency + 1 (DONE then IDLE).
- alu_req is registered-state-derived (Moore). It deasserts in the first cycle after the last iteration.
- The ALU path is combinational: alu_srca/alu_srcb → alu_result → acc. This is a single-cycle path through the external ALU.
- Asynchronous reset mid-RUN: all state is cleared immediately, alu_req and busy fall, and no done pulse is produced.

## Structure
- Shared package:
  - ALU control constants ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_OR = 2'b11.
  - State encoding IDLE / RUN / DONE.
- The ALU stays external and shared. The top level muxes its inputs on alu_gnt.
- No sub-module. A single FSM plus datapath registers (acc, mcand, mplier, 5-bit count) is sufficient.

## Test plan
- MUL a = 7, b = 6, gnt = 1 → result = 42, flags_nz = 00, done 4 cycles after start, exactly 3 RUN cycles with alu_req high.
- MLA a = 3, b = 5, c = 10 → result = 25, flags_nz = 00, done 4 cycles after start.
- MUL a = 0xFFFFFFFF, b = 0xFFFFFFFF → result = 0x00000001, flags_nz = 00, done 33 cycles after start; repeat with EARLY_TERM = 0 and b = 1 → still 33 cycles, result = a.
- MUL a = 0x80000000, b = 2 → result = 0, flags_nz = 01; MUL a = 5, b = 0 → result = 0, Z = 1, done 1 cycle after start with no alu_req.
- MUL a = 7, b = 6 with alu_gnt low for 3 cycles after the first RUN cycle → result = 42, done 7 cycles after start; a start pulse while busy is ignored.
- Reset asserted 5 cycles into a = 0xFFFF, b = 0xFFFF → all outputs 0 immediately, no done pulse. A subsequent MUL a = 2, b = 3 → result = 6.
